muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_signfix.sv | 13 +
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: default width,
// MulFunct bit positions and the FSM state encoding.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam int MF_LONG   = 2;
  localparam int MF_SIGNED = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the main controller (master) and the
// multiply/divide unit (slave).
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic             IsDiv;
  logic [2:0]       MulFunct;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic             DivZero;

  modport master (
    output start, IsDiv, MulFunct, SrcA, SrcB,
    input  busy, done, ResultLo, ResultHi, DivZero
  );

  modport slave (
    input  start, IsDiv, MulFunct, SrcA, SrcB,
    output busy, done, ResultLo, ResultHi, DivZero
  );

endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of products, quotients and remainders.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 shift-add multiplier and restoring divider (WIDTH cycles).
// Divide hardware is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, operand_b;
  logic             op_long, sign_a, sign_b;
  logic [WIDTH-1:0] result_lo, result_hi;
  logic             div_zero;

  logic             a_neg, b_neg, quick_done, last_iter;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fixed;
  logic             mf_rsvd_unused;

`ifdef MULDIV_DIV_EN
  logic             op_div;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] quot_fixed, rem_fixed;
`endif

  assign mf_rsvd_unused = bus.MulFunct[0];

  assign a_neg     = bus.MulFunct[MF_SIGNED] & bus.SrcA[WIDTH-1];
  assign b_neg     = bus.MulFunct[MF_SIGNED] & bus.SrcB[WIDTH-1];
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_DIV_EN
  assign quick_done = bus.IsDiv && (bus.SrcB == '0);
`else
  // Without divide hardware every divide request completes immediately.
  assign quick_done = bus.IsDiv;
`endif

  muldiv_signfix #(.W(WIDTH)) u_abs_a (.neg(a_neg), .din(bus.SrcA), .dout(abs_a));
  muldiv_signfix #(.W(WIDTH)) u_abs_b (.neg(b_neg), .din(bus.SrcB), .dout(abs_b));

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .neg (sign_a ^ sign_b),
    .din ({acc_hi, acc_lo}),
    .dout(prod_fixed)
  );

`ifdef MULDIV_DIV_EN
  muldiv_signfix #(.W(WIDTH)) u_fix_quot (
    .neg(sign_a ^ sign_b), .din(acc_lo), .dout(quot_fixed)
  );
  // Truncating division: the remainder follows the dividend's sign.
  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .neg(sign_a), .din(acc_hi), .dout(rem_fixed)
  );
`endif

  // One iteration. Multiply: {acc_hi,acc_lo} holds partial product and the
  // remaining multiplier bits. Divide: acc_hi is the partial remainder and
  // acc_lo shifts dividend bits out while quotient bits shift in.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, operand_b});
    div_diff  = div_shift - {1'b0, operand_b};
    if (op_div) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_nxt = state;
    bus.busy  = (state != IDLE);
    bus.done  = (state == DONE);
    case (state)
      IDLE:    if (bus.start) state_nxt = quick_done ? DONE : CALC;
      CALC:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_b <= '0;
      op_long   <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      div_zero  <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          div_zero <= 1'b0;
          op_long  <= bus.MulFunct[MF_LONG];
          sign_a   <= a_neg;
          sign_b   <= b_neg;
          cnt      <= '0;
          acc_hi   <= '0;
`ifdef MULDIV_DIV_EN
          op_div    <= bus.IsDiv;
          acc_lo    <= bus.IsDiv ? abs_a : abs_b;
          operand_b <= bus.IsDiv ? abs_b : abs_a;
          if (quick_done) begin
            result_lo <= '0;
            result_hi <= bus.SrcA;
            div_zero  <= 1'b1;
          end
`else
          acc_lo    <= abs_b;
          operand_b <= abs_a;
          if (quick_done) begin
            result_lo <= '0;
            result_hi <= '0;
          end
`endif
        end
        CALC: begin
          cnt    <= cnt + CNT_W'(1);
          acc_hi <= step_hi;
          acc_lo <= step_lo;
        end
        FIX: begin
`ifdef MULDIV_DIV_EN
          if (op_div) begin
            result_lo <= quot_fixed;
            result_hi <= rem_fixed;
          end else
`endif
          begin
            result_lo <= prod_fixed[WIDTH-1:0];
            result_hi <= op_long ? prod_fixed[2*WIDTH-1:WIDTH] : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ResultLo = result_lo;
  assign bus.ResultHi = result_hi;
  assign bus.DivZero  = div_zero;

endmodule
